// File: rtl/mini16sc_loader.sv
// mini16sc_loader: streams a host program into instruction memory, releases the CPU, captures its mailbox result
// Ports: start/load_valid/load_ready/load_data/load_last form the host load handshake;
// mem_i_w_addr/mem_i_w_data/mem_i_we drive the instruction memory write port;
// cpu_soft_reset holds the CPU PC at 0; cpu_mem_d_* snoop CPU data writes;
// busy/done/result/timeout report session status.
// Define MINI16SC_LOADER_TIMEOUT_EN to enable the RUN watchdog (TIMEOUT_CYCLES); otherwise timeout stays 0.
module mini16sc_loader #(
  parameter int WIDTH_I = 16,
  parameter int DEPTH_I = 8,
  parameter int WIDTH_D = 16,
  parameter int DEPTH_D = 8,
  parameter int MAILBOX_ADDR = 255,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [WIDTH_I-1:0] load_data,
  input  logic               load_last,
  output logic [DEPTH_I-1:0] mem_i_w_addr,
  output logic [WIDTH_I-1:0] mem_i_w_data,
  output logic               mem_i_we,
  output logic               cpu_soft_reset,
  input  logic [DEPTH_D-1:0] cpu_mem_d_w_addr,
  input  logic [WIDTH_D-1:0] cpu_mem_d_w_data,
  input  logic               cpu_mem_d_we,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_D-1:0] result,
  output logic               timeout
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;
  logic [DEPTH_I-1:0] cnt;
  logic mbox;
  assign mbox = cpu_mem_d_we && cpu_mem_d_w_addr == DEPTH_D'(MAILBOX_ADDR);
`ifdef MINI16SC_LOADER_TIMEOUT_EN
  logic [31:0] wd;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      load_ready <= 1'b0;
      mem_i_w_addr <= '0;
      mem_i_w_data <= '0;
      mem_i_we <= 1'b0;
      cpu_soft_reset <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      timeout <= 1'b0;
`ifdef MINI16SC_LOADER_TIMEOUT_EN
      wd <= '0;
`endif
    end else begin
      mem_i_we <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state <= LOAD;
          cnt <= '0;
          load_ready <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          timeout <= 1'b0;
        end
        LOAD: if (load_valid && load_ready) begin
          mem_i_we <= 1'b1;
          mem_i_w_addr <= cnt;
          mem_i_w_data <= load_data;
          cnt <= cnt + 1'b1;
          // the last address forces the end of the load so the write pointer never wraps
          if (load_last || &cnt) begin
            state <= RUN;
            load_ready <= 1'b0;
`ifdef MINI16SC_LOADER_TIMEOUT_EN
            wd <= '0;
`endif
          end
        end
        RUN: if (mbox) begin
          state <= DONE;
          result <= cpu_mem_d_w_data;
          done <= 1'b1;
          busy <= 1'b0;
          cpu_soft_reset <= 1'b1;
        end else begin
          // first RUN cycle still sees soft reset, so the CPU starts after the final write lands
          cpu_soft_reset <= 1'b0;
`ifdef MINI16SC_LOADER_TIMEOUT_EN
          wd <= wd + 32'd1;
          if (wd + 32'd1 >= TIMEOUT_CYCLES) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
            cpu_soft_reset <= 1'b1;
            timeout <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mini16sc_loader.sv
// tb_mini16sc_loader: randomized self-checking bench for mini16sc_loader
module tb_mini16sc_loader;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, load_valid = 1'b0, load_last = 1'b0, cpu_we = 1'b0;
  logic [15:0] load_data = '0, cpu_data = '0;
  logic [7:0] cpu_addr = '0;
  logic load_ready, mem_we, sr, busy, done, timeout;
  logic [7:0] mem_addr;
  logic [15:0] mem_data, result;
  logic load_ready2, mem_we2, sr2, busy2, done2, timeout2;
  logic [1:0] mem_addr2;
  logic [15:0] mem_data2, result2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mini16sc_loader #(.TIMEOUT_CYCLES(32'd10)) dut (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .mem_i_w_addr(mem_addr), .mem_i_w_data(mem_data),
    .mem_i_we(mem_we), .cpu_soft_reset(sr), .cpu_mem_d_w_addr(cpu_addr), .cpu_mem_d_w_data(cpu_data),
    .cpu_mem_d_we(cpu_we), .busy(busy), .done(done), .result(result), .timeout(timeout));
  mini16sc_loader #(.DEPTH_I(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .load_valid(load_valid), .load_ready(load_ready2),
    .load_data(load_data), .load_last(load_last), .mem_i_w_addr(mem_addr2), .mem_i_w_data(mem_data2),
    .mem_i_we(mem_we2), .cpu_soft_reset(sr2), .cpu_mem_d_w_addr(cpu_addr), .cpu_mem_d_w_data(cpu_data),
    .cpu_mem_d_we(cpu_we), .busy(busy2), .done(done2), .result(result2), .timeout(timeout2));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0;
    cyc();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc();
    checks++; if ({load_ready, mem_we, mem_addr, mem_data, sr, busy, done, result, timeout} !== {2'b00, 8'h00, 16'h0, 3'b100, 16'h0, 1'b0})
      begin errors++; $display("FAIL reset_values: got rdy%b we%b a%h d%h sr%b busy%b done%b res%h to%b", load_ready, mem_we, mem_addr, mem_data, sr, busy, done, result, timeout); end
    reset = 1'b0;
    cyc();
    checks++; if ({load_ready, sr, busy, done} !== 4'b0100) begin errors++; $display("FAIL reset_idle: got rdy/sr/busy/done %b want 0100", {load_ready, sr, busy, done}); end
  endtask
  task automatic test_basic();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if ({load_ready, busy, sr} !== 3'b111) begin errors++; $display("FAIL basic_load_entry: got rdy/busy/sr %b want 111", {load_ready, busy, sr}); end
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = 16'(16'h1111 * (i + 1)); load_last = (i == 3);
      cyc();
      checks++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 8'(i), 16'(16'h1111 * (i + 1))})
        begin errors++; $display("FAIL basic_write%0d: got we%b a%h d%h want we1 a%h d%h", i, mem_we, mem_addr, mem_data, 8'(i), 16'(16'h1111 * (i + 1))); end
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if ({load_ready, sr, busy} !== 3'b011) begin errors++; $display("FAIL basic_run_entry: got rdy/sr/busy %b want 011", {load_ready, sr, busy}); end
    cyc();
    checks++; if ({mem_we, sr} !== 2'b00) begin errors++; $display("FAIL basic_release: got we/sr %b want 00", {mem_we, sr}); end
    cpu_we = 1'b1; cpu_addr = 8'd254; cpu_data = 16'hBEEF; cyc();
    checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL basic_other_addr: got done/busy %b want 01", {done, busy}); end
    cpu_addr = 8'd255; cpu_data = 16'h1234; cyc(); cpu_we = 1'b0;
    checks++; if ({done, busy, sr, result} !== {3'b101, 16'h1234}) begin errors++; $display("FAIL basic_mailbox: got done%b busy%b sr%b res%h want 1 0 1 1234", done, busy, sr, result); end
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if ({done, load_ready, busy, result} !== {3'b011, 16'h1234}) begin errors++; $display("FAIL basic_restart: got done%b rdy%b busy%b res%h", done, load_ready, busy, result); end
    load_valid = 1'b1; load_data = 16'hCAFE; load_last = 1'b1; cyc(); load_valid = 1'b0; load_last = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 8'h00, 16'hCAFE}) begin errors++; $display("FAIL basic_restart_addr: got we%b a%h d%h want 1 00 cafe", mem_we, mem_addr, mem_data); end
  endtask
  task automatic test_random();
    do_reset();
    for (int it = 0; it < 8; it++) begin
      int n, acc, guard, k;
      logic [15:0] d;
      n = $urandom_range(1, 12); acc = 0; guard = 0;
      start = 1'b1; cyc(); start = 1'b0;
      checks++; if ({load_ready, busy, done} !== 3'b110) begin errors++; $display("FAIL rand_start: got rdy/busy/done %b want 110", {load_ready, busy, done}); end
      while (acc < n && guard < 200) begin
        guard++;
        load_valid = 1'($urandom); load_data = 16'($urandom); load_last = (acc == n - 1); start = 1'($urandom);
        d = load_data;
        cyc();
        checks++; if ({mem_we, sr, busy} !== {load_valid, 2'b11} || (load_valid && {mem_addr, mem_data} !== {8'(acc), d}))
          begin errors++; $display("FAIL rand_write: got we%b sr%b busy%b a%h d%h want we%b a%h d%h", mem_we, sr, busy, mem_addr, mem_data, load_valid, 8'(acc), d); end
        if (load_valid) acc++;
        checks++; if (load_ready !== (acc < n)) begin errors++; $display("FAIL rand_ready: got %b want %b", load_ready, acc < n); end
      end
      checks++; if (guard >= 200) begin errors++; $display("FAIL rand_guard: got %0d words want %0d", acc, n); end
      load_valid = 1'b0; load_last = 1'b0; start = 1'b0;
      cyc();
      checks++; if ({mem_we, sr, load_ready, busy} !== 4'b0001) begin errors++; $display("FAIL rand_run: got we/sr/rdy/busy %b want 0001", {mem_we, sr, load_ready, busy}); end
      k = $urandom_range(0, 4);
      repeat (k) begin
        cpu_we = 1'($urandom); cpu_addr = 8'($urandom_range(0, 254)); cpu_data = 16'($urandom); start = 1'($urandom);
        cyc();
        checks++; if ({done, busy, sr} !== 3'b010) begin errors++; $display("FAIL rand_ignore: got done/busy/sr %b want 010", {done, busy, sr}); end
      end
      start = 1'b0; cpu_we = 1'b1; cpu_addr = 8'd255; d = 16'($urandom); cpu_data = d;
      cyc();
      checks++; if ({done, busy, sr, result} !== {3'b101, d}) begin errors++; $display("FAIL rand_mailbox: got done%b busy%b sr%b res%h want 1 0 1 %h", done, busy, sr, result, d); end
      cpu_data = ~d;
      cyc();
      cpu_we = 1'b0;
      checks++; if ({done, result} !== {1'b1, d}) begin errors++; $display("FAIL rand_hold: got done%b res%h want 1 %h", done, result, d); end
    end
  endtask
  task automatic test_toggle();
    int pulses;
    pulses = 0;
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      load_valid = (i % 2 == 0) && i < 6; load_data = 16'(16'h100 + i); load_last = (i == 4);
      cyc();
      if (mem_we) begin
        checks++; if ({mem_addr, mem_data} !== {8'(pulses), 16'(16'h100 + 2 * pulses)})
          begin errors++; $display("FAIL toggle_write: got a%h d%h want a%h d%h", mem_addr, mem_data, 8'(pulses), 16'(16'h100 + 2 * pulses)); end
        pulses++;
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
    checks++; if (pulses !== 3) begin errors++; $display("FAIL toggle_count: got %0d pulses want 3", pulses); end
  endtask
  task automatic test_wrap();
    logic [15:0] w [6];
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w[i] = 16'($urandom); load_valid = 1'b1; load_data = w[i]; load_last = 1'b0;
      cyc();
      checks++; if (mem_we2 !== (i < 4) || (i < 4 && {mem_addr2, mem_data2} !== {2'(i), w[i]}))
        begin errors++; $display("FAIL wrap_write%0d: got we%b a%h d%h want we%b a%h d%h", i, mem_we2, mem_addr2, mem_data2, i < 4, 2'(i), w[i]); end
      checks++; if (load_ready2 !== (i < 3)) begin errors++; $display("FAIL wrap_ready%0d: got %b want %b", i, load_ready2, i < 3); end
    end
    load_valid = 1'b0;
    checks++; if ({sr2, busy2, done2, timeout2, result2} !== {4'b0100, 16'h0}) begin errors++; $display("FAIL wrap_run: got sr%b busy%b done%b to%b res%h", sr2, busy2, done2, timeout2, result2); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    load_valid = 1'b1; load_data = 16'hA0A0; cyc();
    load_data = 16'hA1A1; cyc();
    load_data = 16'hA2A2;
    #2 reset = 1'b1;
    #1;
    checks++; if ({load_ready, mem_we, mem_addr, mem_data, sr, busy, done, result, timeout} !== {2'b00, 8'h00, 16'h0, 3'b100, 16'h0, 1'b0})
      begin errors++; $display("FAIL midreset_async: got rdy%b we%b a%h d%h sr%b busy%b done%b res%h", load_ready, mem_we, mem_addr, mem_data, sr, busy, done, result); end
    cyc();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL midreset_nowrite: got we%b want 0", mem_we); end
    load_valid = 1'b0; reset = 1'b0;
    cyc();
    start = 1'b1; cyc(); start = 1'b0;
    load_valid = 1'b1; load_data = 16'hB0B0; load_last = 1'b1; cyc(); load_valid = 1'b0; load_last = 1'b0;
    checks++; if ({mem_we, mem_addr, mem_data} !== {1'b1, 8'h00, 16'hB0B0}) begin errors++; $display("FAIL midreset_restart: got we%b a%h d%h want 1 00 b0b0", mem_we, mem_addr, mem_data); end
  endtask
`ifdef MINI16SC_LOADER_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; load_data = 16'h1; cyc(); load_valid = 1'b0; load_last = 1'b0;
    cpu_we = 1'b1; cpu_addr = 8'd255; cpu_data = 16'h5A5A; cyc(); cpu_we = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; cyc(); load_valid = 1'b0; load_last = 1'b0;
    repeat (9) cyc();
    checks++; if ({done, busy, timeout} !== 3'b010) begin errors++; $display("FAIL timeout_early: got done/busy/to %b want 010", {done, busy, timeout}); end
    cyc();
    checks++; if ({done, timeout, busy, sr, result} !== {4'b1101, 16'h5A5A}) begin errors++; $display("FAIL timeout_fire: got done%b to%b busy%b sr%b res%h", done, timeout, busy, sr, result); end
    start = 1'b1; cyc(); start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; cyc(); load_valid = 1'b0; load_last = 1'b0;
    repeat (9) cyc();
    cpu_we = 1'b1; cpu_data = 16'h7777; cyc(); cpu_we = 1'b0;
    checks++; if ({done, timeout, result} !== {2'b10, 16'h7777}) begin errors++; $display("FAIL timeout_race: got done%b to%b res%h want 1 0 7777", done, timeout, result); end
  endtask
`else
  task automatic test_timeout();
    do_reset();
    start = 1'b1; cyc(); start = 1'b0;
    load_valid = 1'b1; load_last = 1'b1; cyc(); load_valid = 1'b0; load_last = 1'b0;
    repeat (30) cyc();
    checks++; if ({done, busy, timeout} !== 3'b010) begin errors++; $display("FAIL no_watchdog: got done/busy/to %b want 010", {done, busy, timeout}); end
  endtask
`endif
  initial begin
    test_reset();
    test_basic();
    test_random();
    test_toggle();
    test_wrap();
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
